// File: rtl/row_fetch_ctrl_pkg.sv
// Shared encodings, default geometry and FSM state type for the row fetch sequencer.
// The FLUSH state only exists when ROW_FETCH_BOTTOM_PAD_EN is defined.
package row_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        SYS_IDLE          = 3'd0,
        SYS_GAUSSIAN      = 3'd1,
        SYS_DETECT_FILTER = 3'd2,
        SYS_END           = 3'd3
    } sys_mode_e;

    localparam int DEF_ROWS    = 480;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_RD_LAT  = 1;
    localparam int DEF_PRIME_G = 6;
    localparam int DEF_PRIME_D = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
`ifdef ROW_FETCH_BOTTOM_PAD_EN
        ST_FLUSH = 2'd2,
`endif
        ST_DONE  = 2'd3
    } fetch_state_e;

    function automatic logic is_pass_mode(input logic [2:0] m);
        return (m == SYS_GAUSSIAN) || (m == SYS_DETECT_FILTER);
    endfunction

endpackage

// File: rtl/row_fetch_ctrl_rd_lat_pipe.sv
// Delay line matching the SRAM read latency: carries {read enable, row index}
// so the buffer write and its row tag land together with the returned data.
module rd_lat_pipe
    import row_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_RD_LAT,
    parameter int W     = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_re,
    input  logic [W-1:0] in_row,
    output logic         out_re,
    output logic [W-1:0] out_row
);

    logic         re_q  [DEPTH];
    logic [W-1:0] row_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                re_q[i]  <= 1'b0;
                row_q[i] <= '0;
            end
        end else begin
            re_q[0]  <= in_re;
            row_q[0] <= in_row;
            for (int i = 1; i < DEPTH; i++) begin
                re_q[i]  <= re_q[i-1];
                row_q[i] <= row_q[i-1];
            end
        end
    end

    assign out_re  = re_q[DEPTH-1];
    assign out_row = row_q[DEPTH-1];

endmodule

// File: rtl/row_fetch_ctrl.sv
// Row fetch sequencer feeding the line buffer: issues SRAM row reads, times buffer
// writes to the read latency and flags complete windows. Optional bottom padding
// for Gaussian passes is enabled by defining ROW_FETCH_BOTTOM_PAD_EN.
module row_fetch_ctrl
    import row_fetch_ctrl_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int RD_LAT  = DEF_RD_LAT,
    parameter int PRIME_G = DEF_PRIME_G,
    parameter int PRIME_D = DEF_PRIME_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode_sel,
    input  logic              stall,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [2:0]        buffer_mode,
    output logic              buffer_we,
    output logic              window_valid,
    output logic [ADDR_W-1:0] win_row,
    output logic              busy,
    output logic              done
);

    localparam int PRIME_MAX = (PRIME_G > PRIME_D) ? PRIME_G : PRIME_D;
    localparam int FILL_W    = $clog2(PRIME_MAX + 1);
    localparam int DRAIN_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [ADDR_W-1:0]  LAST_ROW   = ADDR_W'(ROWS - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(RD_LAT - 1);

    if (ROWS < 1 || ROWS > (1 << ADDR_W)) begin : g_rows_check
        $error("row_fetch_ctrl: ROWS must be in 1..2**ADDR_W");
    end
    if (RD_LAT < 1) begin : g_lat_check
        $error("row_fetch_ctrl: RD_LAT must be at least 1");
    end
    if (PRIME_G < 2 || PRIME_D < 1 || PRIME_G > (1 << ADDR_W)) begin : g_prime_check
        $error("row_fetch_ctrl: PRIME_G must be 2..2**ADDR_W and PRIME_D at least 1");
    end

    fetch_state_e      state_q, state_d;
    logic [2:0]        mode_q;
    logic [ADDR_W-1:0] row_cnt;
    logic              all_issued;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [FILL_W-1:0] fill_cnt;
    logic [FILL_W-1:0] fill_next;
    logic [FILL_W-1:0] prime_sel;
    logic              start_ok;
    logic              is_df;
    logic              flushing;
    logic              shift;
    logic [ADDR_W-1:0] shift_row;
    logic [ADDR_W-1:0] pipe_row;

    assign start_ok  = (state_q == ST_IDLE) && start && is_pass_mode(mode_sel);
    assign is_df     = (mode_q == SYS_DETECT_FILTER);
    assign prime_sel = is_df ? FILL_W'(PRIME_D) : FILL_W'(PRIME_G);

    rd_lat_pipe #(
        .DEPTH (RD_LAT),
        .W     (ADDR_W)
    ) u_rd_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .in_re   (sram_re),
        .in_row  (sram_addr),
        .out_re  (buffer_we),
        .out_row (pipe_row)
    );

`ifdef ROW_FETCH_BOTTOM_PAD_EN
    localparam int FLUSH_W = (PRIME_G > 2) ? $clog2(PRIME_G - 1) : 1;
    localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(PRIME_G - 2);

    logic [FLUSH_W-1:0] flush_cnt;
    logic [ADDR_W:0]    flush_sum;
    logic [ADDR_W-1:0]  flush_row;

    // Padding rows continue the row numbering past the image, pinned at the top code.
    assign flush_sum = {1'b0, LAST_ROW} + (ADDR_W+1)'(flush_cnt) + (ADDR_W+1)'(1);
    assign flush_row = flush_sum[ADDR_W] ? '1 : flush_sum[ADDR_W-1:0];
    assign shift     = buffer_we || flushing;
    assign shift_row = flushing ? flush_row : pipe_row;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            flush_cnt <= '0;
        end else if (flushing) begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
        end
    end
`else
    assign shift     = buffer_we;
    assign shift_row = pipe_row;
`endif

    always_comb begin
        state_d     = state_q;
        sram_re     = 1'b0;
        sram_addr   = '0;
        buffer_mode = SYS_IDLE;
        busy        = (state_q != ST_IDLE);
        done        = 1'b0;
        flushing    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                buffer_mode = mode_q;
                sram_addr   = row_cnt;
                sram_re     = !all_issued && !(is_df && stall);
                if (all_issued && drain_cnt == LAST_DRAIN) begin
`ifdef ROW_FETCH_BOTTOM_PAD_EN
                    state_d = is_df ? ST_DONE : ST_FLUSH;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef ROW_FETCH_BOTTOM_PAD_EN
            ST_FLUSH: begin
                buffer_mode = mode_q;
                flushing    = 1'b1;
                if (flush_cnt == LAST_FLUSH) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                buffer_mode = mode_q;
                done        = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fill_next = (fill_cnt >= prime_sel) ? fill_cnt : fill_cnt + FILL_W'(1);

    // Row counter stops at the last row instead of wrapping; the drain counter
    // then waits out the reads still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= SYS_IDLE;
            row_cnt    <= '0;
            all_issued <= 1'b0;
            drain_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                mode_q     <= mode_sel;
                row_cnt    <= '0;
                all_issued <= 1'b0;
                drain_cnt  <= '0;
            end else begin
                if (sram_re) begin
                    if (row_cnt == LAST_ROW) all_issued <= 1'b1;
                    else row_cnt <= row_cnt + ADDR_W'(1);
                end
                if (state_q == ST_FETCH && all_issued) begin
                    drain_cnt <= drain_cnt + DRAIN_W'(1);
                end
            end
        end
    end

    // A window is ready the cycle after the shift that brings the buffer to PRIME rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt     <= '0;
            window_valid <= 1'b0;
            win_row      <= '0;
        end else begin
            if (start_ok) fill_cnt <= '0;
            else if (shift) fill_cnt <= fill_next;
            window_valid <= shift && (fill_next >= prime_sel);
            if (shift) win_row <= shift_row;
        end
    end

endmodule

// File: tb/tb_row_fetch_ctrl.sv
// Table-driven bench for row_fetch_ctrl (ROWS=8, RD_LAT=2); expectations follow
// ROW_FETCH_BOTTOM_PAD_EN so the same bench covers both builds.
module tb_row_fetch_ctrl;

    localparam int ROWS   = 8;
    localparam int ADDR_W = 9;
    localparam int RD_LAT = 2;
`ifdef ROW_FETCH_BOTTOM_PAD_EN
    localparam int G_LAST    = 16;
    localparam int G_WINDOWS = 8;
`else
    localparam int G_LAST    = 11;
    localparam int G_WINDOWS = 3;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [2:0]        mode_sel;
    logic              stall;
    logic              sram_re;
    logic [ADDR_W-1:0] sram_addr;
    logic [2:0]        buffer_mode;
    logic              buffer_we;
    logic              window_valid;
    logic [ADDR_W-1:0] win_row;
    logic              busy;
    logic              done;

    row_fetch_ctrl #(
        .ROWS    (ROWS),
        .ADDR_W  (ADDR_W),
        .RD_LAT  (RD_LAT),
        .PRIME_G (6),
        .PRIME_D (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode_sel     (mode_sel),
        .stall        (stall),
        .sram_re      (sram_re),
        .sram_addr    (sram_addr),
        .buffer_mode  (buffer_mode),
        .buffer_we    (buffer_we),
        .window_valid (window_valid),
        .win_row      (win_row),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              start;
        logic [2:0]        mode_sel;
        logic              stall;
        logic              re;
        logic              chk_addr;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic              wv;
        logic [ADDR_W-1:0] row;
        logic              busy;
        logic              done;
        logic [2:0]        bmode;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;
    int   ign_lo, ign_hi, g_lo, g_hi, d_lo, d_hi;

    function automatic vec_t idle_vec();
        vec_t v;
        v.rst = 1'b0; v.start = 1'b0; v.mode_sel = 3'd0; v.stall = 1'b0;
        v.re = 1'b0; v.chk_addr = 1'b0; v.addr = '0; v.we = 1'b0;
        v.wv = 1'b0; v.row = '0; v.busy = 1'b0; v.done = 1'b0; v.bmode = 3'd0;
        return v;
    endfunction

    task automatic check_output(input string name, input int cyc,
                                input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, want);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        rst      = v.rst;
        start    = v.start;
        mode_sel = v.mode_sel;
        stall    = v.stall;
        #1;
    endtask

    task automatic run_range(input string name, input int lo, input int hi, input int exp_windows);
        int seen;
        seen = 0;
        for (int i = lo; i <= hi; i++) begin
            apply_stimulus(vecs[i]);
            check_output({name, " sram_re"}, i - lo, 32'(sram_re), 32'(vecs[i].re));
            if (vecs[i].chk_addr)
                check_output({name, " sram_addr"}, i - lo, 32'(sram_addr), 32'(vecs[i].addr));
            check_output({name, " buffer_we"}, i - lo, 32'(buffer_we), 32'(vecs[i].we));
            check_output({name, " window_valid"}, i - lo, 32'(window_valid), 32'(vecs[i].wv));
            if (vecs[i].wv)
                check_output({name, " win_row"}, i - lo, 32'(win_row), 32'(vecs[i].row));
            check_output({name, " busy"}, i - lo, 32'(busy), 32'(vecs[i].busy));
            check_output({name, " done"}, i - lo, 32'(done), 32'(vecs[i].done));
            check_output({name, " buffer_mode"}, i - lo, 32'(buffer_mode), 32'(vecs[i].bmode));
            if (window_valid === 1'b1) seen++;
        end
        check_output({name, " window count"}, hi - lo, 32'(seen), 32'(exp_windows));
    endtask

    function automatic logic [31:0] all_outputs();
        return {13'd0, sram_re, sram_addr, buffer_mode, buffer_we, window_valid, busy, done};
    endfunction

    initial begin
        vec_t v;
        logic [2:0] bad_modes [4];

        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; mode_sel = 3'd0; stall = 1'b0;

        // Starts with an unsupported mode must leave the block idle.
        bad_modes[0] = 3'd3; bad_modes[1] = 3'd0; bad_modes[2] = 3'd7; bad_modes[3] = 3'd4;
        ign_lo = vecs.size();
        for (int k = 0; k < 4; k++) begin
            v = idle_vec(); v.start = 1'b1; v.mode_sel = bad_modes[k];
            vecs.push_back(v);
        end
        vecs.push_back(idle_vec());
        vecs.push_back(idle_vec());
        ign_hi = vecs.size() - 1;

        // Gaussian pass; a stray start at cycle 5 and stalls must not disturb it.
        g_lo = vecs.size();
        for (int c = 0; c < 20; c++) begin
            v = idle_vec();
            v.start    = (c == 0) || (c == 5);
            v.mode_sel = (c == 0) ? 3'd1 : 3'd2;
            v.stall    = (c == 3) || (c == 9);
            v.re       = (c >= 1) && (c <= 8);
            v.chk_addr = v.re;
            v.addr     = ADDR_W'(c - 1);
            v.we       = (c >= 3) && (c <= 10);
            v.wv       = (c >= 9) && (c <= G_LAST);
            v.row      = ADDR_W'(c - 4);
            v.busy     = (c >= 1) && (c <= G_LAST);
            v.done     = (c == G_LAST);
            v.bmode    = v.busy ? 3'd1 : 3'd0;
            vecs.push_back(v);
        end
        g_hi = vecs.size() - 1;

        // Detect/filter pass with stall in cycles 4..6 and an ignored start at 8.
        d_lo = vecs.size();
        for (int c = 0; c < 17; c++) begin
            v = idle_vec();
            v.start    = (c == 0) || (c == 8);
            v.mode_sel = (c == 0) ? 3'd2 : 3'd1;
            v.stall    = (c >= 4) && (c <= 6);
            v.re       = ((c >= 1) && (c <= 3)) || ((c >= 7) && (c <= 11));
            v.chk_addr = (c >= 1) && (c <= 11);
            v.addr     = (c <= 3) ? ADDR_W'(c - 1) : (c <= 7) ? ADDR_W'(3) : ADDR_W'(c - 4);
            v.we       = ((c >= 3) && (c <= 5)) || ((c >= 9) && (c <= 13));
            v.wv       = (c == 5) || (c == 6) || ((c >= 10) && (c <= 14));
            v.row      = (c <= 6) ? ADDR_W'(c - 4) : ADDR_W'(c - 7);
            v.busy     = (c >= 1) && (c <= 14);
            v.done     = (c == 14);
            v.bmode    = v.busy ? 3'd2 : 3'd0;
            vecs.push_back(v);
        end
        d_hi = vecs.size() - 1;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("reset sram_re", 0, 32'(sram_re), 32'd0);
        check_output("reset sram_addr", 0, 32'(sram_addr), 32'd0);
        check_output("reset buffer_mode", 0, 32'(buffer_mode), 32'd0);
        check_output("reset buffer_we", 0, 32'(buffer_we), 32'd0);
        check_output("reset window_valid", 0, 32'(window_valid), 32'd0);
        check_output("reset win_row", 0, 32'(win_row), 32'd0);
        check_output("reset busy", 0, 32'(busy), 32'd0);
        check_output("reset done", 0, 32'(done), 32'd0);

        run_range("ignored", ign_lo, ign_hi, 0);
        run_range("gauss", g_lo, g_hi, G_WINDOWS);
        run_range("detect", d_lo, d_hi, 7);

        // Reset at cycle 5 of a Gaussian pass aborts it with no done pulse.
        v = idle_vec(); v.start = 1'b1; v.mode_sel = 3'd1;
        apply_stimulus(v);
        v = idle_vec();
        for (int c = 1; c <= 4; c++) apply_stimulus(v);
        check_output("abort pre re", 4, 32'(sram_re), 32'd1);
        check_output("abort pre addr", 4, 32'(sram_addr), 32'd3);
        v.rst = 1'b1;
        apply_stimulus(v);
        v.rst = 1'b0;
        for (int c = 6; c <= 25; c++) begin
            apply_stimulus(v);
            check_output("abort outputs", c, all_outputs(), 32'd0);
            check_output("abort win_row", c, 32'(win_row), 32'd0);
        end

        run_range("gauss after reset", g_lo, g_hi, G_WINDOWS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/row_fetch_ctrl.md
# row_fetch_ctrl

Row fetch sequencer that sits directly upstream of the 10-row line buffer. It issues SRAM row reads and drives `buffer_mode` and `buffer_we`, timed so that each row is written into the buffer on the cycle its data arrives from SRAM. It also tells the downstream working module when the buffer holds a complete window. One instance serves both the Gaussian pass and the detect/filter pass.

## Interface
- `ROWS`, 480: image rows per pass.
- `ADDR_W`, 9: SRAM row address width.
- `RD_LAT`, 1: SRAM read latency in cycles, ≥1.
- `PRIME_G`, 6: buffer rows needed for a window in Gaussian mode.
- `PRIME_D`, 2: buffer rows needed for a window in detect/filter mode.

Ports (clock and reset first):
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pass request.
- `mode_sel` in 3: requested pass (SYS_GAUSSIAN or SYS_DETECT_FILTER). Sampled with `start`.
- `stall` in 1: downstream not ready. Honoured only in detect/filter mode.
- `sram_re` out 1: row read enable.
- `sram_addr` out ADDR_W: row address.
- `buffer_mode` out 3: to the line buffer.
- `buffer_we` out 1: to the line buffer.
- `window_valid` out 1: buffer outputs form a valid window this cycle.
- `win_row` out ADDR_W: index of the newest row in the valid window.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle end-of-pass pulse.

## Operation
- FSM states: IDLE → FETCH → (FLUSH) → DONE → IDLE.
- **IDLE.** `buffer_mode` = SYS_IDLE (0), which zeroes the buffer.
  - `start` with `mode_sel` ∈ {1,2} latches the mode, clears the counters and goes to FETCH.
  - `start` with any other `mode_sel` is ignored.
- **FETCH.**
  - `sram_re` is high with `sram_addr` = row counter, 0..ROWS-1. The counter increments on every issued read.
  - Gaussian: one read every cycle. `stall` is ignored, because the buffer shifts every cycle in this mode.
  - Detect/filter: `sram_re` = !`stall`, and the address holds while stalled.
  - After read ROWS-1 is issued:
    - Gaussian with the pad feature compiled in: go to FLUSH.
    - Otherwise: wait for the read pipeline to drain, then go to DONE.
- **FLUSH** (Gaussian only): starts after the pipeline drains. Runs for PRIME_G-1 cycles with `buffer_we`=0, so the buffer shifts in zero rows as bottom padding.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Write enable:** `buffer_we` is `sram_re` delayed by exactly RD_LAT cycles. Reads still in flight when `stall` rises land anyway, so downstream must absorb up to RD_LAT extra rows.
- **Fill counter:** counts buffer shifts, meaning writes plus flush cycles.
  - `window_valid` is high in the cycle after a shift at which fill ≥ PRIME (PRIME_G or PRIME_D by mode).
  - `win_row` = row index of that shift. During flush it is ROWS-1 plus the flush count, saturating at 2^ADDR_W-1.
- **Window counts per pass:**
  - Gaussian with pad: ROWS.
  - Gaussian without pad: ROWS-PRIME_G+1.
  - Detect/filter: ROWS-PRIME_D+1.
- **busy:** high from the cycle after `start` is accepted through DONE inclusive.
- `start` while `busy` is ignored.

## Timing
- **Reset values:** all outputs 0, state IDLE, delay pipeline cleared.
- **Reset mid-pass:** aborts the pass within one cycle. In-flight `buffer_we` are dropped and no `done` is produced.
- **Start latency:** `start` sampled in cycle 0 gives first `sram_re` in cycle 1 and first `buffer_we` in cycle 1+RD_LAT.
- **Window timing:** `window_valid` follows the qualifying shift by 1 cycle. `done` coincides with the final `window_valid`.
- **Stall response:**
  - `stall` rising in cycle n gives `sram_re`=0 in cycle n, combinationally from the registered state.
  - `stall` falling resumes the read in the same cycle.
- **Counter width:** row counter is ADDR_W bits and must not wrap. ROWS ≤ 2^ADDR_W is a parameter check. The fill counter saturates at PRIME.

## Configuration
- Macro `ROW_FETCH_BOTTOM_PAD_EN`.
  - Defined: Gaussian passes include FLUSH and produce ROWS windows.
  - Undefined: FLUSH state and logic are absent, and Gaussian produces ROWS-PRIME_G+1 windows.
  - Detect/filter behaviour is identical either way.

## Structure
- **Shared package:**
  - SYS_IDLE..SYS_END encodings, the same ones the line buffer uses.
  - Default ROWS, PRIME_G and PRIME_D constants.
  - FSM state typedef.
- **Sub-module `rd_lat_pipe`:** RD_LAT-deep shift register carrying {re, row index}, with synchronous clear. Its output drives `buffer_we` and the shift-row tag.

## Test plan
1. **Gaussian with pad.** ROWS=8, RD_LAT=2, `start`+mode 1 at cycle 0.
   - `sram_re` high cycles 1–8 with addr 0–7.
   - `buffer_we` high cycles 3–10, flush shifts cycles 11–15.
   - `window_valid` high cycles 9–16 (8 windows), `done` at cycle 16.
2. **Gaussian without pad** (macro undefined), same stimulus.
   - `window_valid` high cycles 9–11 (3 windows), `done` at cycle 11.
3. **Detect/filter with stall.** ROWS=8, RD_LAT=2, `stall` high cycles 4–6.
   - `sram_re` low cycles 4–6, and addr holds at 3 during the stall.
   - Exactly 7 windows, with `win_row` 1..7 in order.
4. **Reset mid-pass.** `rst` at cycle 5 of case 1.
   - All outputs 0 from cycle 6 and no `done`.
   - A new `start` then runs a complete correct pass.
5. **Ignored starts.**
   - `start` with `mode_sel`=3 in IDLE: stays IDLE and `busy` stays 0.
   - `start` during `busy`: no effect on address sequence or window count.
